// File: rtl/dma_status_irq.sv
// -----------------------------------------------------------------------------
// dma_status_irq
//
// Status/interrupt companion for the PHI2-clocked DMA engine on the expansion
// bus. It watches the engine's BUSY (bus owner) line and does the following:
//   - times each transfer in PHI2 cycles (16-bit run counter, saturating),
//   - counts completed transfers (8-bit, wrapping),
//   - flags transfers that run longer than TIMEOUT cycles (watchdog).
// Status is exposed through an 8-register CPU window at BASE. An open-drain,
// active-low interrupt is raised on completion or timeout.
//
// Parameters
//   TIMEOUT  PHI2 cycles BUSY may stay high before ERR sets (0 = watchdog off)
//   BASE     regaddr of register 0 inside the 32-byte I/O window
//
// Ports
//   PHI2     in   bus clock, all state changes on the rising edge
//   RESB     in   asynchronous active-low reset
//   CS       in   I/O window select, active high
//   RWB      in   1 = CPU read, 0 = CPU write
//   regaddr  in   bus addr[4:0]
//   data     io   CPU data bus; driven only during decoded CPU reads
//   BUSY     in   DMA engine owns the bus
//   IRQB     out  open-drain interrupt: 0 when asserted, Z otherwise
//
// Register map (offset from BASE)
//   0 STATUS  ro  {IRQ,0,0,0,ERR,IEN,DONE,BUSY}
//   1 CTRL    wo  bit0 IEN value, bit1 clear DONE, bit2 clear ERR,
//                 bit3 clear XFERS; reads 00
//   2 DUR_LO  ro  DUR[7:0]; the read also latches DUR[15:8] into a shadow
//   3 DUR_HI  ro  shadow of DUR[15:8] taken by the last DUR_LO read
//   4 XFERS   ro  completed-transfer count
//   5-7           read 00, writes ignored
// -----------------------------------------------------------------------------
module dma_status_irq #(
  parameter logic [15:0] TIMEOUT = 16'hFFFF,
  parameter logic [4:0]  BASE    = 5'h10
) (
  input  logic       PHI2,
  input  logic       RESB,
  input  logic       CS,
  input  logic       RWB,
  input  logic [4:0] regaddr,
  inout  logic [7:0] data,
  input  logic       BUSY,
  output logic       IRQB
);

  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_CTRL   = 3'd1;
  localparam logic [2:0] OFF_DUR_LO = 3'd2;
  localparam logic [2:0] OFF_DUR_HI = 3'd3;
  localparam logic [2:0] OFF_XFERS  = 3'd4;

  logic        busy_q;
  logic [15:0] run_cnt;
  logic [15:0] dur;
  logic [7:0]  dshadow;
  logic [7:0]  xfers;
  logic        done_flag;
  logic        ien;
  logic        err;

  // Transfer edges, seen against the BUSY value registered on the last edge.
  logic start_edge;
  logic done_edge;
  assign start_edge = BUSY & ~busy_q;
  assign done_edge  = ~BUSY & busy_q;

  // Address decode. The window check is done in 6 bits so that a BASE near
  // the top of the 32-byte space cannot wrap around onto low addresses.
  logic [5:0] addr_ext;
  logic [5:0] base_ext;
  logic       in_window;
  logic [4:0] off_full;
  logic [2:0] off;
  assign addr_ext  = {1'b0, regaddr};
  assign base_ext  = {1'b0, BASE};
  assign in_window = (addr_ext >= base_ext) && (addr_ext < base_ext + 6'd8);
  assign off_full  = regaddr - BASE;
  assign off       = off_full[2:0];

  // The CPU may only touch the window while the DMA engine is off the bus;
  // during a transfer addr/data/RWB belong to the engine.
  logic cpu_sel;
  logic rd_en;
  logic wr_ctrl;
  logic rd_dur_lo;
  assign cpu_sel   = CS & ~BUSY & in_window;
  assign rd_en     = cpu_sel & RWB;
  assign wr_ctrl   = cpu_sel & ~RWB & (off == OFF_CTRL);
  assign rd_dur_lo = rd_en & (off == OFF_DUR_LO);

  // Bits 7:4 of a CTRL write carry no function.
  logic unused_data_hi;
  assign unused_data_hi = ^data[7:4];

  // Run counter next value. cnt_step marks the edges where the counter
  // actually moves, so the watchdog fires exactly once per transfer even when
  // the counter sits saturated at TIMEOUT = FFFF.
  logic [15:0] cnt_next;
  logic        cnt_step;
  logic        wd_hit;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_next = run_cnt;
    cnt_step = 1'b0;
    if (start_edge) begin
      cnt_next = 16'd1;
      cnt_step = 1'b1;
    end else if (BUSY && (run_cnt != 16'hFFFF)) begin
      cnt_next = run_cnt + 16'd1;
      cnt_step = 1'b1;
    end
  end

  assign wd_hit = (TIMEOUT != 16'd0) && cnt_step && (cnt_next == TIMEOUT);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge PHI2 or negedge RESB) begin
    if (!RESB) begin
      busy_q    <= 1'b0;
      run_cnt   <= 16'd0;
      dur       <= 16'd0;
      dshadow   <= 8'd0;
      xfers     <= 8'd0;
      done_flag <= 1'b0;
      ien       <= 1'b0;
      err       <= 1'b0;
    end else begin
      busy_q  <= BUSY;
      run_cnt <= cnt_next;

      if (done_edge) dur <= run_cnt;

      // Shadow takes the pre-edge DUR so it pairs with the low byte returned
      // on the bus during this same cycle.
      if (rd_dur_lo) dshadow <= dur[15:8];

      if (wr_ctrl) ien <= data[0];

      // Set beats a coincident write-1-to-clear.
      if (done_edge)                done_flag <= 1'b1;
      else if (wr_ctrl && data[1])  done_flag <= 1'b0;

      if (wd_hit)                   err <= 1'b1;
      else if (wr_ctrl && data[2])  err <= 1'b0;

      // A clear coinciding with a completion counts that completion.
      if (wr_ctrl && data[3])       xfers <= done_edge ? 8'd1 : 8'd0;
      else if (done_edge)           xfers <= xfers + 8'd1;
    end
  end

  logic irq;
  assign irq = ien & (done_flag | err);

  logic [7:0] rdata;
  always_comb begin
    rdata = 8'h00;
    case (off)
      OFF_STATUS: rdata = {irq, 3'b000, err, ien, done_flag, BUSY};
      OFF_DUR_LO: rdata = dur[7:0];
      OFF_DUR_HI: rdata = dshadow;
      OFF_XFERS:  rdata = xfers;
      default:    rdata = 8'h00;
    endcase
  end

  assign data = rd_en ? rdata : 8'hzz;
  assign IRQB = irq ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dma_status_irq.sv
// -----------------------------------------------------------------------------
// Bench for dma_status_irq. A transaction-level model tracks the visible
// register state: consecutive BUSY-high samples, completion count, flags,
// shadow byte. Directed steps follow the feature list, then a randomized phase
// mixes transfers, CTRL writes and reads. Both bus nets carry pull-ups, so a
// released (Z) line reads as all ones.
// -----------------------------------------------------------------------------
module tb_dma_status_irq;

  localparam logic [15:0] TO_P   = 16'd8;
  localparam logic [4:0]  BASE_P = 5'h10;

  logic       clk = 1'b0;
  logic       resb;
  logic       cs;
  logic       rwb;
  logic [4:0] addr;
  logic       busy;
  logic       wdrv;
  logic [7:0] wd;

  wire  [7:0] data_bus;
  wire        irq_bus;

  assign data_bus = wdrv ? wd : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data_bus[g]);
  end
  pullup (irq_bus);

  always #5 clk = ~clk;

  dma_status_irq #(
    .TIMEOUT (TO_P),
    .BASE    (BASE_P)
  ) dut (
    .PHI2    (clk),
    .RESB    (resb),
    .CS      (cs),
    .RWB     (rwb),
    .regaddr (addr),
    .data    (data_bus),
    .BUSY    (busy),
    .IRQB    (irq_bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  bit m_ien, m_done, m_err;
  int m_dur, m_shadow, m_xfers;
  int high_cnt;   // consecutive edges that sampled BUSY high

  task automatic model_reset();
    m_ien = 0; m_done = 0; m_err = 0;
    m_dur = 0; m_shadow = 0; m_xfers = 0;
    high_cnt = 0;
  endtask

  // Applies the effect of one rising edge, using the inputs held across it.
  task automatic model_step();
    bit wr, rd_lo;
    if (!resb) begin
      model_reset();
      return;
    end
    wr    = cs && !rwb && !busy && (addr == BASE_P + 5'd1);
    rd_lo = cs &&  rwb && !busy && (addr == BASE_P + 5'd2);
    if (rd_lo) m_shadow = (m_dur >> 8) & 8'hFF;
    if (wr) begin
      m_ien = wd[0];
      if (wd[1]) m_done  = 0;
      if (wd[2]) m_err   = 0;
      if (wd[3]) m_xfers = 0;
    end
    if (busy) begin
      high_cnt++;
      if (TO_P != 0 && high_cnt == int'(TO_P)) m_err = 1;
    end else if (high_cnt > 0) begin
      m_dur    = (high_cnt > 65535) ? 65535 : high_cnt;
      m_done   = 1;
      m_xfers  = (m_xfers + 1) % 256;
      high_cnt = 0;
    end
  endtask

  function automatic bit exp_irq();
    return m_ien && (m_done || m_err);
  endfunction

  // Expected level on the pulled-up data bus for the current inputs.
  function automatic logic [7:0] exp_read(input logic [4:0] a);
    int off;
    off = int'(a) - int'(BASE_P);
    if (!cs || !rwb || busy || off < 0 || off > 7) return 8'hFF;
    case (off)
      0:       return {exp_irq(), 3'b000, m_err, m_ien, m_done, 1'b0};
      2:       return m_dur[7:0];
      3:       return m_shadow[7:0];
      4:       return m_xfers[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- checking and bus tasks ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk_irq(input string tag);
    check(tag, {15'd0, irq_bus}, {15'd0, ~exp_irq()});
  endtask

  // Presents a read for one cycle; the bus is sampled just after the inputs
  // settle, well away from the rising edge.
  task automatic do_read(input logic [4:0] a, input string tag, output logic [7:0] val);
    cs = 1'b1; rwb = 1'b1; addr = a;
    #1;
    val = data_bus;
    check(tag, {8'd0, val}, {8'd0, exp_read(a)});
    tick();
    cs = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] v);
    cs = 1'b1; rwb = 1'b0; addr = BASE_P + 5'd1; wd = v; wdrv = 1'b1;
    tick();
    cs = 1'b0; rwb = 1'b1; wdrv = 1'b0;
  endtask

  task automatic xfer(input int len);
    busy = 1'b1;
    repeat (len) tick();
    busy = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    resb = 1'b0; cs = 1'b0; rwb = 1'b1; addr = 5'd0;
    busy = 1'b0; wdrv = 1'b0; wd = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    resb = 1'b1;

    // Idle after reset: whole window reads 00, nothing decoded outside it.
    for (int i = 0; i < 8; i++) begin
      do_read(BASE_P + 5'(i), $sformatf("reset_off%0d", i), v);
      check($sformatf("reset_lit_off%0d", i), {8'd0, v}, 16'h0000);
    end
    do_read(BASE_P - 5'd1, "below_window", v);
    do_read(BASE_P + 5'd8, "above_window", v);
    chk_irq("reset_irqb");

    // Basic completion with the interrupt enabled.
    do_write(8'h01);
    xfer(5);
    do_read(BASE_P, "status_after5", v);
    check("status_86", {8'd0, v}, 16'h0086);
    do_read(BASE_P + 5'd2, "dur_lo5", v);
    check("dur_lo_05", {8'd0, v}, 16'h0005);
    do_read(BASE_P + 5'd3, "dur_hi5", v);
    do_read(BASE_P + 5'd4, "xfers1", v);
    check("irqb_low_done", {15'd0, irq_bus}, 16'h0000);
    do_write(8'h03);
    do_read(BASE_P, "status_04", v);
    check("status_lit_04", {8'd0, v}, 16'h0004);
    chk_irq("irqb_released");

    // Watchdog: ERR must assert on the eighth BUSY cycle, mid-transfer.
    busy = 1'b1;
    repeat (7) tick();
    check("irqb_before_to", {15'd0, irq_bus}, 16'h0001);
    tick();
    check("irqb_at_to", {15'd0, irq_bus}, 16'h0000);
    repeat (12) tick();
    busy = 1'b0;
    tick();
    do_read(BASE_P, "status_to", v);
    do_read(BASE_P + 5'd2, "dur_lo20", v);
    check("dur_lo_14", {8'd0, v}, 16'h0014);
    do_read(BASE_P + 5'd3, "dur_hi20", v);
    do_write(8'h04);
    do_read(BASE_P, "status_err_clr", v);
    check("done_kept_err_clr", {14'd0, v[3], v[1]}, 16'h0001);

    // XFERS wrap.
    do_write(8'h08);
    for (int i = 0; i < 256; i++) xfer(1);
    do_read(BASE_P + 5'd4, "xfers_wrap", v);
    check("xfers_lit_00", {8'd0, v}, 16'h0000);
    xfer(2);
    do_read(BASE_P + 5'd4, "xfers_one", v);
    do_write(8'h08);
    do_read(BASE_P + 5'd4, "xfers_clr", v);

    // Bus owned by the engine: reads float, CTRL writes are dropped.
    busy = 1'b1;
    tick();
    do_read(BASE_P, "rd_busy_status", v);
    check("rd_busy_z", {8'd0, v}, 16'h00FF);
    do_read(BASE_P + 5'd4, "rd_busy_xfers", v);
    do_write(8'h0F);
    tick();
    busy = 1'b0;
    tick();
    do_read(BASE_P, "status_wr_ignored", v);
    do_read(BASE_P + 5'd4, "xfers_wr_ignored", v);

    // Done edge in the same cycle as a DONE clear: the set wins.
    busy = 1'b1;
    repeat (3) tick();
    busy = 1'b0;
    do_write(8'h02);
    do_read(BASE_P, "status_done_wins", v);
    check("done_wins_bit", {15'd0, v[1]}, 16'h0001);

    // Randomized mix.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 4))
        0: xfer($urandom_range(1, 12));
        1: do_write(8'($urandom_range(0, 15)));
        2: do_read(BASE_P - 5'd2 + 5'($urandom_range(0, 11)), "rnd_read", v);
        3: begin
          do_read(BASE_P + 5'd2, "rnd_dur_lo", v);
          do_read(BASE_P + 5'd3, "rnd_dur_hi", v);
        end
        default: begin
          busy = 1'b1;
          repeat ($urandom_range(1, 4)) tick();
          do_read(BASE_P + 5'($urandom_range(0, 4)), "rnd_busy_read", v);
          if ($urandom_range(0, 1) == 1) do_write(8'($urandom_range(0, 15)));
          busy = 1'b0;
          tick();
        end
      endcase
      chk_irq("rnd_irqb");
    end

    // Reset in the middle of a transfer with the interrupt asserted.
    do_write(8'h01);
    busy = 1'b1;
    repeat (4) tick();
    chk_irq("pre_reset_irqb");
    check("pre_reset_irqb_low", {15'd0, irq_bus}, 16'h0000);
    resb = 1'b0;
    model_reset();
    #1;
    check("reset_irqb_immediate", {15'd0, irq_bus}, 16'h0001);
    busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_read(BASE_P + 5'(i), $sformatf("in_reset_off%0d", i), v);
      check($sformatf("in_reset_lit%0d", i), {8'd0, v}, 16'h0000);
    end
    // BUSY already high when reset releases counts as a fresh start.
    busy = 1'b1;
    tick();
    resb = 1'b1;
    repeat (3) tick();
    busy = 1'b0;
    tick();
    do_read(BASE_P + 5'd2, "dur_after_reset", v);
    check("dur_after_reset_lit", {8'd0, v}, 16'h0003);
    do_read(BASE_P + 5'd4, "xfers_after_reset", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
